// File: rtl/gol_vga_pkg.sv
// Shared constants and types for the Game-of-Life VGA renderer.
// Contents: 640x480@60Hz timing constants (raw and as counter-width values),
// the rgb12_t colour type and the palette used for blanking, dead cells,
// live cells and cell-border lines.
package gol_vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter-width copies so comparisons against hcnt/vcnt are width-matched.
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
  localparam cnt_t V_PRE_BL = cnt_t'(V_VIS - 1);
  localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t COL_BLANK = 12'h000;
  localparam rgb12_t COL_DEAD  = 12'h112;
  localparam rgb12_t COL_LIVE  = 12'h0F0;
  localparam rgb12_t COL_LINE  = 12'h444;

endpackage

// File: rtl/gol_vga_if.sv
// VGA video bundle: active-low syncs plus 12-bit colour.
// master: the renderer driving the monitor; slave: anything observing it.
interface gol_vga_if;
  logic       hsync_out;
  logic       vsync_out;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (output hsync_out, vsync_out, red, green, blue);
  modport slave  (input  hsync_out, vsync_out, red, green, blue);
endinterface

// File: rtl/gol_vga_timing.sv
// vga_timing: 640x480@60Hz raster generator on a 50 MHz clock.
// Ports:
//   clk, rst (async, active-low)
//   pix_en       /2 pixel enable, first high on the 2nd clk after release
//   hcnt, vcnt   raster position, advance only when pix_en=1
//   hsync_raw    unregistered-stage horizontal sync (active-low)
//   vsync_raw    unregistered-stage vertical sync (active-low)
//   visible      current position is inside the 640x480 active area
//   frame_start  pix_en edge that moves the raster from (799,479) to (0,480)
//   frame_tick   registered one-clk pulse following frame_start
module vga_timing
  import gol_vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic visible,
  output logic frame_start,
  output logic frame_tick
);

  assign frame_start = pix_en && (hcnt == H_LAST) && (vcnt == V_PRE_BL);
  assign hsync_raw   = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
  assign vsync_raw   = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
  assign visible     = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en     <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      frame_tick <= 1'b0;
    end else begin
      pix_en     <= ~pix_en;
      frame_tick <= frame_start;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          // Both counters wrap together at (799,524); frame_start cannot fire there.
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + cnt_t'(1);
        end else begin
          hcnt <= hcnt + cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gol_vga_renderer.sv
// gol_vga_renderer: draws a GRID_N x GRID_N Game-of-Life grid, centred, on a
// 640x480@60Hz VGA output. The grid is snapshotted at vblank start (same edge
// as frame_tick) so the picture never tears while the grid steps.
// Ports:
//   clk         50 MHz system clock
//   rst         asynchronous, active-low reset
//   cells_in    live-cell vector, bit r*GRID_N+c = row r, column c
//   frame_tick  one-clk pulse at vblank start
//   vga         gol_vga_if.master: hsync_out, vsync_out, red, green, blue
// Build option: define GOL_GRID_LINES_EN to draw 0x444 borders on the first
// pixel row/column of every cell inside the window.
module gol_vga_renderer
  import gol_vga_pkg::*;
#(
  parameter int GRID_N     = 20,
  parameter int CELL_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [GRID_N*GRID_N-1:0] cells_in,
  output logic                     frame_tick,
  gol_vga_if.master                vga
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int IDX_W = $clog2(NCELL);
  localparam int WIN   = GRID_N << CELL_SHIFT;
  localparam int X0    = H_VIS / 2 - WIN / 2;
  localparam int Y0    = V_VIS / 2 - WIN / 2;

  logic pix_en, hsync_raw, vsync_raw, visible, frame_start;
  cnt_t hcnt, vcnt;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .visible     (visible),
    .frame_start (frame_start),
    .frame_tick  (frame_tick)
  );

  logic [NCELL-1:0] snapshot;

  // ---- stage p0: window test and cell lookup from the raster position ----
  // Positions left/above the window wrap to large unsigned offsets, so a
  // single "< WIN" compare covers both window edges.
  cnt_t          xo_p0, yo_p0, col_p0, row_p0;
  logic          in_win_p0, cell_p0;
  logic [IDX_W-1:0] idx_p0;
  rgb12_t        col_rgb_p0;

  assign xo_p0     = hcnt - cnt_t'(X0);
  assign yo_p0     = vcnt - cnt_t'(Y0);
  assign in_win_p0 = (xo_p0 < cnt_t'(WIN)) && (yo_p0 < cnt_t'(WIN));
  assign col_p0    = xo_p0 >> CELL_SHIFT;
  assign row_p0    = yo_p0 >> CELL_SHIFT;
  assign idx_p0    = IDX_W'(int'(row_p0) * GRID_N + int'(col_p0));
  assign cell_p0   = in_win_p0 && snapshot[idx_p0];

  always_comb begin
    col_rgb_p0 = COL_BLANK;
    if (visible && in_win_p0) begin
`ifdef GOL_GRID_LINES_EN
      if ((xo_p0[CELL_SHIFT-1:0] == '0) || (yo_p0[CELL_SHIFT-1:0] == '0)) begin
        col_rgb_p0 = COL_LINE;
      end else begin
        col_rgb_p0 = cell_p0 ? COL_LIVE : COL_DEAD;
      end
`else
      col_rgb_p0 = cell_p0 ? COL_LIVE : COL_DEAD;
`endif
    end
  end

  // ---- stage p1: registered outputs, syncs share the colour register ----
  logic   hsync_p1, vsync_p1;
  rgb12_t rgb_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      rgb_p1   <= COL_BLANK;
    end else begin
      if (frame_start) begin
        snapshot <= cells_in;
      end
      if (pix_en) begin
        hsync_p1 <= hsync_raw;
        vsync_p1 <= vsync_raw;
        rgb_p1   <= col_rgb_p0;
      end
    end
  end

  assign vga.hsync_out = hsync_p1;
  assign vga.vsync_out = vsync_p1;
  assign vga.red       = rgb_p1.r;
  assign vga.green     = rgb_p1.g;
  assign vga.blue      = rgb_p1.b;

endmodule

// File: tb/tb_gol_vga_renderer.sv
// Scoreboard bench for gol_vga_renderer. A reference process derives, from
// the number of clocks since reset release, which pixel the output register
// should hold and pushes the expected syncs/colour/tick into a queue; a
// monitor on the falling edge pops and compares every clock.
module tb_gol_vga_renderer;
  import gol_vga_pkg::*;

  localparam int GRID_N     = 20;
  localparam int CELL_SHIFT = 4;
  localparam int CELL       = 1 << CELL_SHIFT;
  localparam int NCELL      = GRID_N * GRID_N;
  localparam int WIN        = GRID_N * CELL;
  localparam int X0         = 320 - WIN / 2;
  localparam int Y0         = 240 - WIN / 2;
  localparam int FRAME_PIX  = 800 * 525;
  localparam int TICK_PIX   = 800 * 480;
  localparam int MAX_FAILS  = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCELL-1:0] cells = '0;
  logic             frame_tick;

  gol_vga_if vga ();

  gol_vga_renderer #(.GRID_N(GRID_N), .CELL_SHIFT(CELL_SHIFT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cells_in   (cells),
    .frame_tick (frame_tick),
    .vga        (vga)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        tick;
    logic [9:0]  h;
    logic [9:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Colour of screen position (h,v) given the grid picture s.
  function automatic logic [11:0] ref_colour(int h, int v, logic [NCELL-1:0] s);
    if (h >= 640 || v >= 480) return 12'h000;
    if (h < X0 || h >= X0 + WIN || v < Y0 || v >= Y0 + WIN) return 12'h000;
`ifdef GOL_GRID_LINES_EN
    if ((h - X0) % CELL == 0 || (v - Y0) % CELL == 0) return 12'h444;
`endif
    return s[((v - Y0) / CELL) * GRID_N + (h - X0) / CELL] ? 12'h0F0 : 12'h112;
  endfunction

  // Reference model: pixel p is latched on the (2p+2)-th edge after release.
  int unsigned      edges = 0;
  logic [NCELL-1:0] snap_m = '0;

  always @(posedge clk) begin
    exp_t        e;
    int unsigned m, q, h, v;
    e = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000, tick: 1'b0, h: 10'd0, v: 10'd0};
    if (!rst) begin
      edges  = 0;
      snap_m = '0;
    end else begin
      edges = edges + 1;
      if (edges >= 2) begin
        m     = edges / 2;
        q     = (m - 1) % FRAME_PIX;
        h     = q % 800;
        v     = q / 800;
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !(h >= 656 && h < 752);
        e.vs  = !(v >= 490 && v < 492);
        e.rgb = ref_colour(int'(h), int'(v), snap_m);
        if (edges % 2 == 0 && m % FRAME_PIX == TICK_PIX) begin
          e.tick = 1'b1;
          snap_m = cells;
        end
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] act, req;
    if (exp_q.size() > 0 && failures < MAX_FAILS) begin
      e   = exp_q.pop_front();
      act = {vga.hsync_out, vga.vsync_out, vga.red, vga.green, vga.blue, frame_tick};
      req = {e.hs, e.vs, e.rgb, e.tick};
      checks = checks + 1;
      if (act !== req) begin
        failures = failures + 1;
        $display("FAIL px h=%0d v=%0d got hs,vs,rgb,tick=%b,%b,%03h,%b required %b,%b,%03h,%b",
                 e.h, e.v, act[14], act[13], act[12:1], act[0], req[14], req[13], req[12:1], req[0]);
      end
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  end

  task automatic check_bit(string name, logic act, logic req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s got %b required %b", name, act, req);
    end
  endtask

  task automatic rand_cells(output logic [NCELL-1:0] r);
    for (int i = 0; i < NCELL; i++) r[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    logic [NCELL-1:0] pat;
    logic [NCELL-1:0] junk;

    wait_clks(3);
    rst = 1'b1;

    // A few lines of frame 0, then reset in the middle of a line.
    rand_cells(junk);
    cells = junk;
    wait_clks(2 * (3 * 800 + 333));
    rst = 1'b0;
    #1;
    check_bit("rst_hsync", vga.hsync_out, 1'b1);
    check_bit("rst_vsync", vga.vsync_out, 1'b1);
    check_bit("rst_rgb_zero", |{vga.red, vga.green, vga.blue}, 1'b0);
    check_bit("rst_tick", frame_tick, 1'b0);
    wait_clks(3);
    rst = 1'b1;

    // Frame 0: snapshot still empty, so the window shows dead cells; a change
    // at v=200 must stay invisible. Pattern for the next frame is loaded
    // before vblank with cell (0,0) alive.
    wait_clks(2 * 800 * 200);
    rand_cells(junk);
    cells = junk;
    wait_clks(2 * 800 * 150);
    rand_cells(pat);
    pat[0] = 1'b1;
    cells  = pat;

    // Past the tick (v=480) and into vblank: all-ones must not show in frame 1.
    wait_clks(2 * 800 * 145);
    cells = '1;

    // Frame 1: rows 0 and 1 of the grid, cells_in toggling randomly meanwhile.
    for (int k = 0; k < 4; k++) begin
      wait_clks(2 * 800 * 30);
      rand_cells(junk);
      cells = junk;
    end
    wait_clks(2 * 800 * 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
